arb_conv_8_32: RTL and testbench

//  Round-robin arbiter and sequencer sharing one 8->32 byte packer among N byte-stream lanes.

---
 rtl/conv_pkg.sv | 14 +
 rtl/arb_conv_8_32_rr_pick.sv | 24 ++
 rtl/arb_conv_8_32.sv | 172 +++++++++++++++++
 tb/tb_arb_conv_8_32.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the lane arbiter feeding the 8->32 byte packer.
package conv_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
   localparam int WORD_CNT_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/arb_conv_8_32_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping around.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] gnt_idx_o,
   output logic         any_req_o
);

   // Walk from the farthest candidate back to ptr_i+1 so the nearest requester wins.
   always_comb begin
      gnt_idx_o = '0;
      any_req_o = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) begin
            gnt_idx_o = W'((int'(ptr_i) + k) % N);
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_conv_8_32.sv
// Round-robin sequencer: grants one lane for whole 4-byte words and forwards its bytes,
// with at least one idle cycle between words so the downstream packer realigns.
module arb_conv_8_32
   import conv_pkg::*;
#(
   parameter int N_LANES         = 4,
   parameter int LANE_W          = 2,
   parameter int WORDS_PER_GRANT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_LANES-1:0]     valid_in,
   input  logic [8*N_LANES-1:0]   data_in,
   output logic [N_LANES-1:0]     ready_out,
   output logic                   valid_0,
   output logic [7:0]             data_out,
   output logic [LANE_W-1:0]      lane_out,
   output logic                   sop,
   output logic                   word_done,
   output logic                   abort,
   output logic [1:0]             dbg_state_o
);

   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [WORD_CNT_W:0]   WPG_L     = (WORD_CNT_W + 1)'(WORDS_PER_GRANT);

   // Handshake: a byte moves when valid_in[k] & ready_out[k] at a rising edge; ready_out is
   // one-hot on the granted lane only while bursting, and sources hold their byte until taken.

   state_t                  state_q, state_d;
   logic [LANE_W-1:0]       gnt_q, gnt_d;
   logic [LANE_W-1:0]       ptr_q, ptr_d;
   logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [N_LANES-1:0]      ready_q, ready_d;
   logic                    valid_q, valid_d;
   logic [7:0]              data_q, data_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic                    sop_q, sop_d;
   logic                    done_q, done_d;
   logic                    abort_q, abort_d;

   logic [LANE_W-1:0]       pick_idx;
   logic                    pick_any;
   logic                    cur_valid;
   logic [7:0]              cur_byte;
   logic [WORD_CNT_W:0]     words_next;

   rr_pick #(
      .N (N_LANES),
      .W (LANE_W)
   ) u_pick (
      .req_i     (valid_in),
      .ptr_i     (ptr_q),
      .gnt_idx_o (pick_idx),
      .any_req_o (pick_any)
   );

   assign cur_valid  = valid_in[gnt_q];
   assign cur_byte   = data_in[{gnt_q, 3'b000} +: 8];
   assign words_next = {1'b0, word_cnt_q} + (WORD_CNT_W + 1)'(1);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      lane_d     = lane_q;
      sop_d      = 1'b0;
      done_d     = 1'b0;
      abort_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gnt_d      = pick_idx;
               ptr_d      = pick_idx;
               byte_cnt_d = '0;
               state_d    = ST_BURST;
            end
         end

         ST_BURST: begin
            if (cur_valid) begin
               valid_d    = 1'b1;
               data_d     = cur_byte;
               lane_d     = gnt_q;
               sop_d      = (byte_cnt_q == '0);
               done_d     = (byte_cnt_q == LAST_BYTE);
               byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
               if (byte_cnt_q == LAST_BYTE) begin
                  if (words_next < WPG_L) begin
                     word_cnt_d = words_next[WORD_CNT_W-1:0];
                     state_d    = ST_GAP;
                  end else begin
                     word_cnt_d = '0;
                     state_d    = ST_IDLE;
                  end
               end
            end else begin
               // Lane gave up mid-word: drop the partial word; ptr_q already points at it.
               abort_d    = 1'b1;
               byte_cnt_d = '0;
               word_cnt_d = '0;
               state_d    = ST_IDLE;
            end
         end

         ST_GAP: begin
            if (cur_valid) begin
               byte_cnt_d = '0;
               state_d    = ST_BURST;
            end else begin
               word_cnt_d = '0;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = '0;
      if (state_d == ST_BURST) begin
         ready_d[gnt_d] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         ptr_q      <= LANE_W'(N_LANES - 1);
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         ready_q    <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         lane_q     <= '0;
         sop_q      <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         lane_q     <= lane_d;
         sop_q      <= sop_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
      end
   end

   assign ready_out   = ready_q;
   assign valid_0     = valid_q;
   assign data_out    = data_q;
   assign lane_out    = lane_q;
   assign sop         = sop_q;
   assign word_done   = done_q;
   assign abort       = abort_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arb_conv_8_32.sv
// Bench for arb_conv_8_32: two instances (one word per grant, two words per grant), each fed by
// queue-backed byte sources and compared every cycle against a behavioural lane-ownership model.
module tb_arb_conv_8_32;

   localparam int N  = 4;
   localparam int LW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [N-1:0]      vin  [2];
   logic [8*N-1:0]    din  [2];
   logic [N-1:0]      rdy  [2];
   logic              v0   [2];
   logic [7:0]        dout [2];
   logic [LW-1:0]     lout [2];
   logic              sopw [2];
   logic              wd   [2];
   logic              ab   [2];
   logic [1:0]        st   [2];

   arb_conv_8_32 #(.N_LANES(N), .LANE_W(LW), .WORDS_PER_GRANT(1)) u_wpg1 (
      .clk(clk), .reset(reset), .valid_in(vin[0]), .data_in(din[0]), .ready_out(rdy[0]),
      .valid_0(v0[0]), .data_out(dout[0]), .lane_out(lout[0]), .sop(sopw[0]),
      .word_done(wd[0]), .abort(ab[0]), .dbg_state_o(st[0]));

   arb_conv_8_32 #(.N_LANES(N), .LANE_W(LW), .WORDS_PER_GRANT(2)) u_wpg2 (
      .clk(clk), .reset(reset), .valid_in(vin[1]), .data_in(din[1]), .ready_out(rdy[1]),
      .valid_0(v0[1]), .data_out(dout[1]), .lane_out(lout[1]), .sop(sopw[1]),
      .word_done(wd[1]), .abort(ab[1]), .dbg_state_o(st[1]));

   // Model: which lane owns the packer, how far into its word it is, and whether it must
   // sit out one cycle before its next word of the same grant.
   typedef struct {
      int ptr;
      int owner;
      bit pause;
      int pos;
      int words;
      int wpg;
      bit e_valid;
      int e_data;
      int e_lane;
      bit e_sop;
      bit e_done;
      bit e_abort;
   } model_t;

   model_t         m [2];
   logic [7:0]     bq [2][N][$];
   bit             en [2][N];
   logic [N-1:0]   acc [2];
   logic [7:0]     obs_b [2][$];
   int             obs_l [2][$];
   int             n_abort [2];
   int             n_rdy [2];
   int             n_checks = 0;
   int             n_err = 0;
   int             cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] m_ready(input int i);
      if (m[i].owner >= 0 && !m[i].pause) return N'(1) << m[i].owner;
      return '0;
   endfunction

   function automatic logic [17:0] m_pack(input int i);
      return {m_ready(i), m[i].e_valid, 8'(m[i].e_data), 2'(m[i].e_lane),
              m[i].e_sop, m[i].e_done, m[i].e_abort};
   endfunction

   function automatic logic [17:0] dut_pack(input int i);
      return {rdy[i], v0[i], dout[i], lout[i], sopw[i], wd[i], ab[i]};
   endfunction

   function automatic logic [63:0] pack_obs(input int i);
      logic [63:0] r;
      r = 64'(obs_l[i].size()) << 56;
      for (int j = 0; j < obs_l[i].size() && j < 5; j++) r |= 64'(obs_l[i][j] & 15) << (4 * j);
      return r;
   endfunction

   function automatic logic [63:0] pack_l(input int n, input int a, input int b, input int c,
                                          input int d, input int e);
      return (64'(n) << 56) | 64'(a) | (64'(b) << 4) | (64'(c) << 8) | (64'(d) << 12) | (64'(e) << 16);
   endfunction

   task automatic model_step(input int i);
      logic [N-1:0] v;
      bit found;
      int l;
      v = vin[i];
      acc[i] = reset ? '0 : (v & m_ready(i));
      m[i].e_valid = 1'b0;
      m[i].e_sop   = 1'b0;
      m[i].e_done  = 1'b0;
      m[i].e_abort = 1'b0;
      if (reset) begin
         m[i].ptr = N - 1; m[i].owner = -1; m[i].pause = 1'b0;
         m[i].pos = 0; m[i].words = 0; m[i].e_data = 0; m[i].e_lane = 0;
      end else if (m[i].owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            l = (m[i].ptr + k) % N;
            if (!found && v[l]) begin
               found = 1'b1; m[i].owner = l; m[i].ptr = l; m[i].pos = 0;
            end
         end
      end else if (m[i].pause) begin
         m[i].pause = 1'b0;
         if (!v[m[i].owner]) begin m[i].owner = -1; m[i].words = 0; end
      end else if (v[m[i].owner]) begin
         m[i].e_valid = 1'b1;
         m[i].e_data  = int'(din[i][8*m[i].owner +: 8]);
         m[i].e_lane  = m[i].owner;
         m[i].e_sop   = (m[i].pos == 0);
         m[i].e_done  = (m[i].pos == 3);
         m[i].pos     = (m[i].pos + 1) % 4;
         if (m[i].pos == 0) begin
            m[i].words++;
            if (m[i].words < m[i].wpg) m[i].pause = 1'b1;
            else begin m[i].owner = -1; m[i].words = 0; end
         end
      end else begin
         m[i].e_abort = 1'b1; m[i].owner = -1; m[i].pos = 0; m[i].words = 0;
      end
   endtask

   task automatic src_drive();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < N; k++) begin
            vin[i][k] = en[i][k] && (bq[i][k].size() > 0);
            din[i][8*k +: 8] = (bq[i][k].size() > 0) ? bq[i][k][0] : 8'h00;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("cyc%0d_u%0d", cyc, i), 64'(dut_pack(i)), 64'(m_pack(i)));
         if (v0[i]) obs_b[i].push_back(dout[i]);
         if (wd[i]) obs_l[i].push_back(int'(lout[i]));
         if (ab[i]) n_abort[i]++;
         if (rdy[i] != '0) n_rdy[i]++;
         for (int k = 0; k < N; k++) if (acc[i][k]) void'(bq[i][k].pop_front());
      end
      src_drive();
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 2; i++) begin
         obs_b[i].delete(); obs_l[i].delete(); n_abort[i] = 0; n_rdy[i] = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) for (int k = 0; k < N; k++) begin
         bq[i][k].delete(); en[i][k] = 1'b1;
      end
      src_drive();
      cycle();
      cycle();
      chk("reset_zero_u0", 64'(dut_pack(0)), 64'd0);
      chk("reset_zero_u1", 64'(dut_pack(1)), 64'd0);
      reset = 1'b0;
      clear_obs();
   endtask

   task automatic push_both(input int k, input logic [7:0] b);
      bq[0][k].push_back(b);
      bq[1][k].push_back(b);
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m[i].owner = -1; m[i].ptr = N - 1; m[i].pause = 1'b0; m[i].pos = 0; m[i].words = 0;
         vin[i] = '0; din[i] = '0;
      end
      m[0].wpg = 1;
      m[1].wpg = 2;

      // Lane 2 alone sends AA BB CC DD.
      do_reset();
      push_both(2, 8'hAA); push_both(2, 8'hBB); push_both(2, 8'hCC); push_both(2, 8'hDD);
      src_drive();
      repeat (8) cycle();
      chk("s2_bytes", {32'(obs_b[0].size()), (obs_b[0].size() == 4) ?
          {obs_b[0][0], obs_b[0][1], obs_b[0][2], obs_b[0][3]} : 32'h0}, {32'd4, 32'hAABBCCDD});
      chk("s2_lanes", pack_obs(0), pack_l(1, 2, 0, 0, 0, 0));
      chk("s2_ready_cycles", 64'(n_rdy[0]), 64'd4);

      // All four lanes busy; five words in total.
      do_reset();
      for (int k = 0; k < N; k++) for (int b = 0; b < 4; b++) push_both(k, 8'($urandom));
      for (int b = 0; b < 4; b++) push_both(0, 8'($urandom));
      src_drive();
      repeat (40) cycle();
      chk("s3_order_wpg1", pack_obs(0), pack_l(5, 0, 1, 2, 3, 0));
      chk("s3_order_wpg2", pack_obs(1), pack_l(5, 0, 0, 1, 2, 3));
      chk("s3_no_abort", 64'(n_abort[0] + n_abort[1]), 64'd0);

      // Lane 1 stops after two bytes while lane 2 waits.
      do_reset();
      push_both(1, 8'h11); push_both(1, 8'h12);
      for (int b = 0; b < 4; b++) push_both(2, 8'(8'h20 + b));
      src_drive();
      repeat (20) cycle();
      chk("s4_abort", 64'(n_abort[0]), 64'd1);
      chk("s4_lanes", pack_obs(0), pack_l(1, 2, 0, 0, 0, 0));
      chk("s4_bytes", 64'(obs_b[0].size()), 64'd6);

      // Lanes 0 and 3, two words each.
      do_reset();
      for (int b = 0; b < 8; b++) begin push_both(0, 8'($urandom)); push_both(3, 8'($urandom)); end
      src_drive();
      repeat (50) cycle();
      chk("s5_order_wpg2", pack_obs(1), pack_l(4, 0, 0, 3, 3, 0));
      chk("s5_order_wpg1", pack_obs(0), pack_l(4, 0, 3, 0, 3, 0));

      // Reset lands right after the third byte of a word.
      do_reset();
      for (int b = 0; b < 4; b++) begin push_both(0, 8'($urandom)); push_both(1, 8'($urandom)); end
      src_drive();
      for (int t = 0; t < 20 && obs_b[0].size() < 3; t++) cycle();
      chk("s6_third_byte", 64'(obs_b[0].size()), 64'd3);
      reset = 1'b1;
      cycle();
      chk("s6_reset_zero_u0", 64'(dut_pack(0)), 64'd0);
      chk("s6_reset_zero_u1", 64'(dut_pack(1)), 64'd0);
      reset = 1'b0;
      clear_obs();
      for (int b = 0; b < 3; b++) push_both(0, 8'($urandom));
      src_drive();
      repeat (20) cycle();
      chk("s6_after_reset", pack_obs(0), pack_l(2, 0, 1, 0, 0, 0));

      // Lane 3 alone for three words.
      do_reset();
      for (int b = 0; b < 12; b++) push_both(3, 8'($urandom));
      src_drive();
      repeat (25) cycle();
      chk("s7_lanes_wpg1", pack_obs(0), pack_l(3, 3, 3, 3, 0, 0));
      chk("s7_lanes_wpg2", pack_obs(1), pack_l(3, 3, 3, 3, 0, 0));
      chk("s7_bytes", 64'(obs_b[0].size()), 64'd12);

      // Random traffic with valid drops and occasional reset.
      do_reset();
      for (int t = 0; t < 2000; t++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) begin
               if (bq[i][k].size() < 3 && $urandom_range(0, 2) == 0) bq[i][k].push_back(8'($urandom));
               if ($urandom_range(0, 19) == 0) en[i][k] = !en[i][k];
            end
         end
         src_drive();
         cycle();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
